// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default reset PC and the reset active level.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

    // Level of rst at which the block is held in reset.
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one read at a time on a
// valid/ready bus and presents {pc, inst, err} to the downstream stage.
// Redirects retarget the PC; an in-flight request is completed on the bus
// and its response discarded.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_tgt_q;
    logic [ADDR_W-1:0] w_tgt_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] w_inst_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [ADDR_W-1:0] w_redir_tgt;

    assign w_redir_tgt = redirect_pc & ~ADDR_W'(3);

    // Outputs are pure decodes of registered state.
    assign mem_arvalid = (r_state == ST_REQ);
    assign mem_araddr  = r_pc;
    assign mem_rready  = (r_state == ST_WAIT);
    assign out_valid   = (r_state == ST_HOLD);
    assign out_pc      = r_pc;
    assign out_inst    = r_inst;
    assign out_err     = r_err;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt_q <= '0;
            r_drop  <= 1'b0;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt_q <= w_tgt_nxt;
            r_drop  <= w_drop_nxt;
            r_inst  <= w_inst_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic; redirect takes priority over normal transitions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt_q;
        w_drop_nxt  = r_drop;
        w_inst_nxt  = r_inst;
        w_err_nxt   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_tgt;
                end
            end
            ST_REQ: begin
                // Address stays on the bus until accepted; only the target is latched.
                if (redirect_valid) begin
                    w_tgt_nxt  = w_redir_tgt;
                    w_drop_nxt = 1'b1;
                end
                if (mem_arready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_tgt_nxt  = w_redir_tgt;
                    w_drop_nxt = 1'b1;
                end
                if (mem_rvalid) begin
                    if (redirect_valid) begin
                        w_pc_nxt    = w_redir_tgt;
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else if (r_drop) begin
                        w_pc_nxt    = r_tgt_q;
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_inst_nxt  = mem_rdata;
                        w_err_nxt   = |mem_rresp;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_tgt;
                    w_state_nxt = ST_REQ;
                end else if (out_ready) begin
                    w_pc_nxt    = r_pc + ADDR_W'(4);
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
